// File: rtl/fft_iter_agu.sv
// fft_iter_agu: address generator and stage sequencer for an in-place
// radix-2 DIT iterative FFT.
//   Sequence: IDLE -> RUN -> DRAIN -> (RUN, next stage | DONE) -> IDLE.
//   RUN issues one butterfly per cycle. DRAIN waits BUT_LAT cycles so that
//   the write-backs of stage s land before stage s+1 reads.
// Ports:
//   CLK, RST (async active-low), EN (clock enable; freezes everything)
//   START, i_LOG2N, i_INV   : start request, log2 size and inverse flag (latched)
//   o_RD_A/B_ADDR, o_RD_VALID : butterfly read addresses
//   o_W_ADDR, o_W_CONJ      : twiddle ROM index and conjugate flag
//   o_WR_A/B_ADDR, o_WR_EN  : read addresses delayed by BUT_LAT EN-cycles
//   o_STAGE, o_BUSY, o_DONE : stage index, RAM block flag, completion pulse
// Optional build macro FFT_AGU_BITREV_LOAD_EN adds a LOAD state before RUN.
// In LOAD, input samples are written at bit-reversed addresses
// (i_IN_VALID in, o_LD_ADDR / o_LD_WE out).
module fft_iter_agu #(
  parameter int AWL     = 8,
  parameter int BUT_LAT = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic                     START,
  input  logic [$clog2(AWL+1)-1:0] i_LOG2N,
  input  logic                     i_INV,
`ifdef FFT_AGU_BITREV_LOAD_EN
  input  logic                     i_IN_VALID,
  output logic [AWL-1:0]           o_LD_ADDR,
  output logic                     o_LD_WE,
`endif
  output logic [AWL-1:0]           o_RD_A_ADDR,
  output logic [AWL-1:0]           o_RD_B_ADDR,
  output logic                     o_RD_VALID,
  output logic [AWL-2:0]           o_W_ADDR,
  output logic                     o_W_CONJ,
  output logic [AWL-1:0]           o_WR_A_ADDR,
  output logic [AWL-1:0]           o_WR_B_ADDR,
  output logic                     o_WR_EN,
  output logic [$clog2(AWL)-1:0]   o_STAGE,
  output logic                     o_BUSY,
  output logic                     o_DONE
);
  localparam int LW = $clog2(AWL+1);
  localparam int SW = $clog2(AWL);
  localparam int CW = $clog2(BUT_LAT+1);
  localparam int DW = 2*AWL + 1;

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef FFT_AGU_BITREV_LOAD_EN
    S_LOAD,
`endif
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [LW-1:0]               l_q, l_d, l_start;
  logic [SW-1:0]               s_q, s_d;
  logic [AWL-2:0]              j_q, j_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        inv_q, inv_d;
  logic [AWL-1:0]              rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic [AWL-2:0]              w_q, w_d;
  logic                        rd_valid_q, rd_valid_d;
  logic                        busy_q, busy_d, done_q, done_d;
  logic [BUT_LAT-1:0][DW-1:0]  dl_q, dl_d;
  logic [AWL-1:0]              half, jx, pos, a_calc;
  logic [AWL-2:0]              w_calc;
  logic                        j_last, cnt_last, s_last;
`ifdef FFT_AGU_BITREV_LOAD_EN
  logic [AWL-1:0]              k_q, k_d, br;
  logic [AWL-1:0]              ld_addr_q, ld_addr_d;
  logic                        ld_we_q, ld_we_d;
  logic                        k_last;
`endif

  always_comb begin
    // Size clamped to 1..AWL
    l_start = i_LOG2N;
    if (i_LOG2N == '0)             l_start = LW'(1);
    else if (int'(i_LOG2N) > AWL)  l_start = LW'(AWL);

    j_last   = (j_q == (AWL-1)'(((32'd1 << l_q) >> 1) - 32'd1));
    cnt_last = (cnt_q == CW'(BUT_LAT-1));
    s_last   = ((int'(s_q) + 1) >= int'(l_q));

    state_d = state_q;
    l_d     = l_q;
    s_d     = s_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
`ifdef FFT_AGU_BITREV_LOAD_EN
    k_d       = k_q;
    ld_addr_d = ld_addr_q;
    ld_we_d   = 1'b0;
    k_last    = (k_q == AWL'((32'd1 << l_q) - 32'd1));
    // Bit-reverse of the sample count over the low l_q bits
    br = '0;
    for (int i = 0; i < AWL; i++)
      if (i < int'(l_q)) br[int'(l_q)-1-i] = k_q[i];
`endif

    case (state_q)
      S_IDLE: if (START) begin
        l_d   = l_start;
        inv_d = i_INV;
        s_d   = '0;
        j_d   = '0;
        cnt_d = '0;
`ifdef FFT_AGU_BITREV_LOAD_EN
        k_d     = '0;
        state_d = S_LOAD;
`else
        state_d = S_RUN;
`endif
      end
`ifdef FFT_AGU_BITREV_LOAD_EN
      S_LOAD: if (i_IN_VALID) begin
        ld_we_d   = 1'b1;
        ld_addr_d = br;
        if (k_last) state_d = S_RUN;
        else        k_d     = k_q + AWL'(1);
      end
`endif
      S_RUN: begin
        if (j_last) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          j_d = j_q + (AWL-1)'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_last) begin
          if (s_last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            s_d     = s_q + SW'(1);
            j_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Addresses for the next cycle: insert a 0 at bit s of j to get A
    half   = AWL'(1) << s_d;
    jx     = AWL'(j_d);
    pos    = jx & (half - AWL'(1));
    a_calc = ((jx >> s_d) << (32'(s_d) + 32'd1)) | pos;
    w_calc = (AWL-1)'(pos << (AWL - 1 - int'(s_d)));

    rd_valid_d = (state_d == S_RUN);
    rd_a_d     = rd_valid_d ? a_calc : '0;
    rd_b_d     = rd_valid_d ? (a_calc | half) : '0;
    w_d        = rd_valid_d ? w_calc : '0;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);

    dl_d[0] = {rd_a_q, rd_b_q, rd_valid_q};
    for (int i = 1; i < BUT_LAT; i++) dl_d[i] = dl_q[i-1];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      l_q        <= '0;
      s_q        <= '0;
      j_q        <= '0;
      cnt_q      <= '0;
      inv_q      <= 1'b0;
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      w_q        <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dl_q       <= '0;
`ifdef FFT_AGU_BITREV_LOAD_EN
      k_q        <= '0;
      ld_addr_q  <= '0;
      ld_we_q    <= 1'b0;
`endif
    end else if (EN) begin
      state_q    <= state_d;
      l_q        <= l_d;
      s_q        <= s_d;
      j_q        <= j_d;
      cnt_q      <= cnt_d;
      inv_q      <= inv_d;
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
      w_q        <= w_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dl_q       <= dl_d;
`ifdef FFT_AGU_BITREV_LOAD_EN
      k_q        <= k_d;
      ld_addr_q  <= ld_addr_d;
      ld_we_q    <= ld_we_d;
`endif
    end
  end

  assign o_RD_A_ADDR = rd_a_q;
  assign o_RD_B_ADDR = rd_b_q;
  assign o_RD_VALID  = rd_valid_q;
  assign o_W_ADDR    = w_q;
  assign o_W_CONJ    = inv_q;
  assign o_WR_A_ADDR = dl_q[BUT_LAT-1][DW-1 -: AWL];
  assign o_WR_B_ADDR = dl_q[BUT_LAT-1][AWL:1];
  assign o_WR_EN     = dl_q[BUT_LAT-1][0];
  assign o_STAGE     = s_q;
  assign o_BUSY      = busy_q;
  assign o_DONE      = done_q;
`ifdef FFT_AGU_BITREV_LOAD_EN
  assign o_LD_ADDR   = ld_addr_q;
  assign o_LD_WE     = ld_we_q;
`endif
endmodule

// File: tb/tb_fft_iter_agu.sv
// Bench for fft_iter_agu (default build). A schedule-level model expands a
// transform into a per-cycle list of expected outputs. A compare step after
// every clock checks the DUT against that list and against the write-back
// history.
module tb_fft_iter_agu;
  localparam int AWL = 8, BUT_LAT = 4;
  localparam int LW = $clog2(AWL+1), SW = $clog2(AWL);

  logic CLK = 1'b0;
  logic RST, EN, START, i_INV;
  logic [LW-1:0]  i_LOG2N;
  logic [AWL-1:0] o_RD_A_ADDR, o_RD_B_ADDR, o_WR_A_ADDR, o_WR_B_ADDR;
  logic [AWL-2:0] o_W_ADDR;
  logic [SW-1:0]  o_STAGE;
  logic o_RD_VALID, o_W_CONJ, o_WR_EN, o_BUSY, o_DONE;

  fft_iter_agu #(.AWL(AWL), .BUT_LAT(BUT_LAT)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START), .i_LOG2N(i_LOG2N), .i_INV(i_INV),
    .o_RD_A_ADDR(o_RD_A_ADDR), .o_RD_B_ADDR(o_RD_B_ADDR), .o_RD_VALID(o_RD_VALID),
    .o_W_ADDR(o_W_ADDR), .o_W_CONJ(o_W_CONJ), .o_WR_A_ADDR(o_WR_A_ADDR),
    .o_WR_B_ADDR(o_WR_B_ADDR), .o_WR_EN(o_WR_EN), .o_STAGE(o_STAGE),
    .o_BUSY(o_BUSY), .o_DONE(o_DONE));

  always #5 CLK = ~CLK;

  typedef struct { bit valid; int a; int b; int w; int stage; bit busy; bit done; } rec_t;
  typedef struct { bit v; int a; int b; } wr_t;

  rec_t gen[$];
  rec_t sched[$];
  rec_t cur;
  wr_t  dlq[$];
  bit   m_inv;
  int   checks = 0, failures = 0;
  int   wall, done_wall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: dut=%0d exp=%0d cycle=%0d", name, act, exp, wall);
    end
  endtask

  // Expand a transform of size 2^L into its expected per-cycle outputs.
  task automatic build(input int lraw);
    int l, n, half;
    rec_t r;
    l = (lraw < 1) ? 1 : ((lraw > AWL) ? AWL : lraw);
    n = 1 << l;
    gen.delete();
    for (int s = 0; s < l; s++) begin
      half = 1 << s;
      for (int j = 0; j < n/2; j++) begin
        r = '{default:0};
        r.valid = 1; r.busy = 1; r.stage = s;
        r.a = (j / half) * 2 * half + (j % half);
        r.b = r.a + half;
        r.w = (j % half) * ((1 << (AWL-1)) / half);
        gen.push_back(r);
      end
      for (int d = 0; d < BUT_LAT; d++) begin
        r = '{default:0}; r.busy = 1; gen.push_back(r);
      end
    end
    r = '{default:0}; r.busy = 1; r.done = 1;
    gen.push_back(r);
  endtask

  task automatic model_reset();
    sched.delete();
    cur = '{default:0};
    dlq.delete();
    for (int i = 0; i < BUT_LAT; i++) dlq.push_back('{0, 0, 0});
    m_inv = 0;
  endtask

  // One EN-qualified clock edge of the model.
  task automatic model_edge();
    dlq.push_front('{cur.valid, cur.a, cur.b});
    void'(dlq.pop_back());
    if (!cur.busy && START) begin
      build(int'(i_LOG2N));
      sched = gen;
      m_inv = i_INV;
    end
    if (sched.size() > 0) cur = sched.pop_front();
    else                  cur = '{default:0};
  endtask

  task automatic check_all();
    chk("rd_valid", o_RD_VALID, cur.valid);
    chk("busy", o_BUSY, cur.busy);
    chk("done", o_DONE, cur.done);
    if (cur.valid) begin
      chk("rd_a", o_RD_A_ADDR, cur.a);
      chk("rd_b", o_RD_B_ADDR, cur.b);
      chk("w_addr", o_W_ADDR, cur.w);
      chk("stage", o_STAGE, cur.stage);
      chk("w_conj", o_W_CONJ, m_inv);
    end
    chk("wr_en", o_WR_EN, dlq[BUT_LAT-1].v);
    if (dlq[BUT_LAT-1].v) begin
      chk("wr_a", o_WR_A_ADDR, dlq[BUT_LAT-1].a);
      chk("wr_b", o_WR_B_ADDR, dlq[BUT_LAT-1].b);
    end
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_rd_a"}, o_RD_A_ADDR, 0);  chk({tag, "_rd_b"}, o_RD_B_ADDR, 0);
    chk({tag, "_rd_v"}, o_RD_VALID, 0);   chk({tag, "_w"}, o_W_ADDR, 0);
    chk({tag, "_conj"}, o_W_CONJ, 0);     chk({tag, "_wr_a"}, o_WR_A_ADDR, 0);
    chk({tag, "_wr_b"}, o_WR_B_ADDR, 0);  chk({tag, "_wr_en"}, o_WR_EN, 0);
    chk({tag, "_stage"}, o_STAGE, 0);     chk({tag, "_busy"}, o_BUSY, 0);
    chk({tag, "_done"}, o_DONE, 0);
  endtask

  task automatic tick();
    @(posedge CLK);
    if (EN) model_edge();
    #1;
    wall++;
    check_all();
    if (o_DONE === 1'b1 && done_wall < 0) done_wall = wall;
  endtask

  // mode 0: EN=1; mode 1: random EN/START/inputs; mode 2: EN low for edges
  // 10..12 and a START pulse at edge 14.
  task automatic run(input int lraw, input bit inv, input int mode,
                     input int exp_done, input int abort_at);
    int guard = 0;
    i_LOG2N = LW'(lraw); i_INV = inv; EN = 1; START = 1;
    wall = 0; done_wall = -1;
    tick();
    START = 0;
    while (cur.busy && guard < 20000) begin
      if (abort_at >= 0 && wall == abort_at) break;
      case (mode)
        1: begin
          EN = ($urandom_range(0, 3) != 0);
          START = ($urandom_range(0, 7) == 0);
          i_LOG2N = LW'($urandom_range(0, 9));
          i_INV = 1'($urandom);
        end
        2: begin EN = !(wall >= 10 && wall < 13); START = (wall == 14); end
        default: begin EN = 1; START = 0; end
      endcase
      tick();
      guard++;
    end
    EN = 1; START = 0;
    if (abort_at >= 0) begin
      RST = 0; #1;
      model_reset();
      zero_check("rst_mid");
      #3 RST = 1;
    end else begin
      chk("run_finished", (guard < 20000), 1);
      if (exp_done >= 0) chk("done_cycle", done_wall, exp_done);
    end
    repeat (3) tick();
  endtask

  initial begin
    EN = 0; START = 0; i_INV = 0; i_LOG2N = '0; wall = 0; done_wall = -1;
    RST = 1; #1 RST = 0; #1;
    model_reset();
    zero_check("rst");
    @(posedge CLK); #3 RST = 1;

    // Model pins: L=3 schedule against hand-derived values
    build(3);
    chk("pin_len", gen.size(), 25);
    chk("pin_s0_a", gen[0].a, 0);   chk("pin_s0_b", gen[0].b, 1);
    chk("pin_s1_a", gen[9].a, 1);   chk("pin_s1_b", gen[9].b, 3);
    chk("pin_s1_w", gen[9].w, 64);
    chk("pin_s2_w1", gen[17].w, 32);
    chk("pin_s2_a", gen[19].a, 3);  chk("pin_s2_b", gen[19].b, 7);
    chk("pin_s2_w3", gen[19].w, 96);

    run(3, 0, 0, 25, -1);          // basic L=3
    run(8, 1, 0, 1057, -1);        // full size, inverse
    run(0, 0, 0, 6, -1);           // clamp low
    run(AWL+1, 0, 0, 1057, -1);    // clamp high
    run(3, 0, 2, 28, -1);          // EN freeze + ignored START
    run(3, 0, 0, -1, 6);           // reset mid-DRAIN
    run(3, 1, 0, 25, -1);          // clean run after reset
    for (int r = 0; r < 6; r++)
      run($urandom_range(0, 9), 1'($urandom), 1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_iter_agu.md
Name: fft_iter_agu

Overview:
Address generation unit and stage sequencer for the in-place radix-2 DIT iterative FFT core. It generates butterfly read addresses, twiddle indices and pipeline-delayed write-back addresses, and it drives the RAM block flag. It generalises the current fixed-size sequencing in three ways: transform size is selectable at run time up to 2^AWL, butterfly latency is a parameter, and an inverse-transform flag is supported. It sits between top-level START control and the dual-port data RAM, twiddle ROM and butterfly pipeline.

Parameters:
AWL, 8, max log2 of transform size; RAM address width
BUT_LAT, 4, butterfly pipeline latency in EN-qualified cycles (>=1)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
EN  input  1  clock enable; low freezes all state, counters and delay line
START  input  1  start request, sampled in IDLE only
i_LOG2N  input  $clog2(AWL+1)  log2 transform size, latched at START
i_INV  input  1  inverse transform, latched at START
o_RD_A_ADDR  output  AWL  butterfly top operand address
o_RD_B_ADDR  output  AWL  butterfly bottom operand address
o_RD_VALID  output  1  read addresses valid this cycle
o_W_ADDR  output  AWL-1  twiddle ROM index (table of 2^(AWL-1) entries)
o_W_CONJ  output  1  conjugate the twiddle (= latched inverse flag)
o_WR_A_ADDR  output  AWL  write-back top address
o_WR_B_ADDR  output  AWL  write-back bottom address
o_WR_EN  output  1  write-back strobe
o_STAGE  output  $clog2(AWL)  current stage index s
o_BUSY  output  1  RAM block; external RAM access forbidden
o_DONE  output  1  one-cycle completion pulse

Behaviour:
- Reset (RST=0, async): state IDLE; all outputs 0; delay line cleared.
- Effective size L = clamp(i_LOG2N, 1, AWL), latched at START; N=2^L.
- States: IDLE -> RUN -> DRAIN -> (RUN with s+1 | DONE) -> IDLE. All transitions require EN=1.
- IDLE: START=1 -> RUN, with s=0 and j=0. START in any other state is ignored.
- RUN: one butterfly per cycle, j = 0..N/2-1, with o_RD_VALID=1.
  - half = 2^s, pos = j & (half-1), grp = j >> s.
  - A = (grp << (s+1)) | pos; B = A + half; W = pos << (AWL-1-s).
  - After j = N/2-1 -> DRAIN.
- DRAIN: BUT_LAT cycles, o_RD_VALID=0, so the last writes of stage s land before stage s+1 reads. At the end, s<L-1 -> RUN (s+1, j=0); otherwise -> DONE.
- DONE: o_DONE=1 for exactly one cycle, then IDLE.
- Timing: START sampled at cycle 0 gives first RUN at cycle 1 and o_DONE at cycle 1 + L*(N/2+BUT_LAT).
- o_BUSY=1 in RUN, DRAIN and DONE; 0 in IDLE.
- Write-back: {A, B, o_RD_VALID} pass through a BUT_LAT-deep register delay line that advances only when EN=1. Its output drives o_WR_A_ADDR, o_WR_B_ADDR and o_WR_EN.
- EN=0 mid-operation: every output holds its value. o_DONE, if high, stays high until the next EN=1 cycle.
- Reset mid-operation aborts immediately; no pending write-back is emitted.
- All outputs are registered; none is combinational from inputs.

Optional Feature:
Macro FFT_AGU_BITREV_LOAD_EN adds input pins i_IN_VALID (1b) and outputs o_LD_ADDR (AWL) and o_LD_WE (1b).
- With the macro defined: START enters state LOAD before RUN, with o_BUSY=1.
  - Each EN-cycle with i_IN_VALID=1 emits o_LD_WE=1 and o_LD_ADDR = bit-reverse over L bits of the sample count k (upper AWL-L bits 0).
  - After N accepted samples -> RUN.
  - The DONE cycle becomes 1 + N + L*(N/2+BUT_LAT) when i_IN_VALID is held high.
- Without the macro: LOAD state and those ports are absent; input reordering is external.

Test Plan:
1. L=3, BUT_LAT=4, EN=1, START pulse -> stage 0 pairs (0,1)(2,3)(4,5)(6,7), W=0; stage 1 pairs (0,2)(1,3)(4,6)(5,7), W=0,64,0,64; stage 2 pairs (0,4)(1,5)(2,6)(3,7), W=0,32,64,96; o_DONE at cycle 25.
2. Same run -> each o_WR_EN pulse carries the read addresses of exactly 4 cycles earlier; no read in stage s+1 precedes the last write of stage s.
3. L=8 with i_INV=1 -> 128 reads per stage, o_W_CONJ=1 throughout, o_DONE at cycle 1057, o_BUSY high cycles 1..1057.
4. i_LOG2N=0 -> treated as L=1: single pair (0,1), o_DONE at cycle 6. i_LOG2N=AWL+1 -> identical to AWL.
5. Toggle EN low for 3 cycles mid-RUN plus START pulse during RUN -> outputs frozen for 3 cycles, START ignored, o_DONE delayed by exactly 3 cycles.
6. Assert RST mid-DRAIN -> all outputs 0 immediately; a new START performs a clean full run.
